// File: rtl/riot_io_timer.sv
// riot_io_timer: RIOT-style peripheral core with NPORTS bidirectional ports, an 8-bit interval
// timer with 1/8/64/1024 prescale, and optional per-port edge-detect interrupts.
// Define RIOT_EDGE_IRQ_EN to build the edge-detect logic and the register 17 edge control.
module riot_io_timer #(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned PW     = 8,
    parameter int unsigned AW     = 5
) (
    input  logic                 phi2,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 we_n,
    input  logic [AW-1:0]        addr,
    input  logic [7:0]           di,
    output logic [7:0]           do_,
    output logic                 oe,
    input  logic [NPORTS*PW-1:0] pin_i,
    output logic [NPORTS*PW-1:0] port_o,
    output logic [NPORTS*PW-1:0] ddr_o,
    output logic                 irq_n
);
    localparam int unsigned NB = NPORTS * PW;

    logic wr, rd, ld, rd_cnt;
    assign wr     = cs & ~we_n;
    assign rd     = cs & we_n;
    assign oe     = rd;
    assign ld     = wr && (addr >= AW'(8)) && (addr <= AW'(15));
    assign rd_cnt = rd && (addr == AW'(16));

    logic [NB-1:0] port_q, port_d, ddr_q, ddr_d;
    logic [7:0]    count_q, count_d;
    logic [1:0]    presc_q, presc_d;
    logic [9:0]    pcnt_q, pcnt_d, plim;
    logic          tirq_en_q, tirq_en_d, tflag_q, tflag_d, tick;
    logic          irq_n_q, irq_n_d;
    logic [3:0]    edge_flag, edge_act;

    assign port_o = port_q;
    assign ddr_o  = ddr_q;
    assign irq_n  = irq_n_q;

    // Port data/direction write decode; addresses of absent ports match nothing.
    always_comb begin
        port_d = port_q;
        ddr_d  = ddr_q;
        if (wr) begin
            for (int p = 0; p < int'(NPORTS); p++) begin
                if (addr == AW'(2 * p))     port_d[p*PW +: PW] = di[PW-1:0];
                if (addr == AW'(2 * p + 1)) ddr_d[p*PW +: PW]  = di[PW-1:0];
            end
        end
    end

    // Prescaler terminal count for the selected divide ratio.
    always_comb begin
        case (presc_q)
            2'd0:    plim = 10'd0;
            2'd1:    plim = 10'd7;
            2'd2:    plim = 10'd63;
            default: plim = 10'd1023;
        endcase
    end
    assign tick = (pcnt_q == plim);

    // Timer next state: a load overrides a same-cycle tick; a timeout beats a count read.
    always_comb begin
        count_d   = count_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        tirq_en_d = tirq_en_q;
        tflag_d   = tflag_q & ~rd_cnt;
        if (ld) begin
            count_d   = di;
            presc_d   = addr[1:0];
            tirq_en_d = addr[2];
            pcnt_d    = '0;
            tflag_d   = 1'b0;
        end else if (tick) begin
            pcnt_d = '0;
            if (count_q == 8'h00) begin
                // After timeout the counter free-runs at /1 until reloaded.
                count_d = 8'hFF;
                presc_d = 2'd0;
                tflag_d = 1'b1;
            end else begin
                count_d = count_q - 8'd1;
            end
        end else begin
            pcnt_d = pcnt_q + 10'd1;
        end
    end

`ifdef RIOT_EDGE_IRQ_EN
    localparam logic [3:0] PMASK = 4'((1 << NPORTS) - 1);

    logic       rd_stat, wr_ctl, prev_vld_q;
    logic [3:0] msb, prev_q, en_q, en_d, pol_q, pol_d, flag_q, flag_d, hit;

    assign rd_stat = rd && (addr == AW'(17));
    assign wr_ctl  = wr && (addr == AW'(17));

    // Gather the MSB of each port; absent ports stay 0.
    always_comb begin
        msb = '0;
        for (int p = 0; p < int'(NPORTS); p++) msb[p] = pin_i[p*PW + PW - 1];
    end

    // prev_vld_q suppresses a spurious edge against the reset value of prev_q.
    assign hit = {4{prev_vld_q}} & en_q &
                 ((~prev_q & msb & pol_q) | (prev_q & ~msb & ~pol_q));

    // Edge control and flags: a fresh edge survives a simultaneous status read.
    always_comb begin
        en_d   = en_q;
        pol_d  = pol_q;
        flag_d = (flag_q & ~{4{rd_stat}}) | hit;
        if (wr_ctl) begin
            en_d  = di[3:0] & PMASK;
            pol_d = di[7:4] & PMASK;
        end
    end

    // Edge-detect state registers.
    always_ff @(posedge phi2) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            en_q       <= '0;
            pol_q      <= '0;
            flag_q     <= '0;
        end else begin
            prev_q     <= msb;
            prev_vld_q <= 1'b1;
            en_q       <= en_d;
            pol_q      <= pol_d;
            flag_q     <= flag_d;
        end
    end

    assign edge_flag = flag_q;
    assign edge_act  = flag_q & en_q;
`else
    assign edge_flag = '0;
    assign edge_act  = '0;
`endif

    assign irq_n_d = ~((tflag_q & tirq_en_q) | (|edge_act));

    // Read data: combinational from addr and current state, zero-extended to 8 bits.
    always_comb begin
        do_ = 8'h00;
        for (int p = 0; p < int'(NPORTS); p++) begin
            if (addr == AW'(2 * p)) begin
                do_[PW-1:0] = (ddr_q[p*PW +: PW] & port_q[p*PW +: PW]) |
                              (~ddr_q[p*PW +: PW] & pin_i[p*PW +: PW]);
            end
            if (addr == AW'(2 * p + 1)) do_[PW-1:0] = ddr_q[p*PW +: PW];
        end
        if (addr == AW'(16)) do_ = count_q;
        if (addr == AW'(17)) do_ = {tflag_q, 3'b000, edge_flag};
    end

    // Port, timer and interrupt registers; reset wins over any access.
    always_ff @(posedge phi2) begin
        if (rst) begin
            port_q    <= '0;
            ddr_q     <= '0;
            count_q   <= 8'hFF;
            presc_q   <= 2'd3;
            pcnt_q    <= '0;
            tirq_en_q <= 1'b0;
            tflag_q   <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            port_q    <= port_d;
            ddr_q     <= ddr_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            tirq_en_q <= tirq_en_d;
            tflag_q   <= tflag_d;
            irq_n_q   <= irq_n_d;
        end
    end

endmodule

// File: tb/tb_riot_io_timer.sv
// tb_riot_io_timer: scenario tasks for riot_io_timer (2x8 instance plus a 1x4 instance on the
// same bus). Expected values are queued when stimulus is driven and popped at the check point.
module tb_riot_io_timer;
    logic        phi2, rst, cs, we_n;
    logic [4:0]  addr;
    logic [7:0]  di, do0, do1;
    logic        oe0, oe1, irq0, irq1;
    logic [15:0] pin0, port0, ddr0;
    logic [3:0]  pin1, port1, ddr1;

    logic [15:0] sb[$];
    logic [15:0] got, exp;
    int          errors, checks;

    riot_io_timer #(.NPORTS(2), .PW(8), .AW(5)) u_dut (
        .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .addr(addr), .di(di), .do_(do0),
        .oe(oe0), .pin_i(pin0), .port_o(port0), .ddr_o(ddr0), .irq_n(irq0)
    );

    riot_io_timer #(.NPORTS(1), .PW(4), .AW(5)) u_dut1 (
        .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .addr(addr), .di(di), .do_(do1),
        .oe(oe1), .pin_i(pin1), .port_o(port1), .ddr_o(ddr1), .irq_n(irq1)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    // Bus tasks are entered and left at a falling edge with the bus idle.
    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        cs = 1'b1; we_n = 1'b0; addr = a; di = d;
        @(negedge phi2);
        cs = 1'b0; we_n = 1'b1;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
        cs = 1'b1; we_n = 1'b1; addr = a;
        #1 d = do0;
        @(negedge phi2);
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge phi2);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0001);
        got = port0; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_port_o: got %h want %h", got, exp); end
        got = ddr0; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_ddr_o: got %h want %h", got, exp); end
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_irq_n: got %h want %h", got, exp); end
        sb.push_back(16'h00FF); sb.push_back(16'h0000);
        addr = 5'd16; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_count: got %h want %h", got, exp); end
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_status: got %h want %h", got, exp); end
        sb.push_back(16'h0003); sb.push_back(16'h0000);
        cs = 1'b1; #1 got = {14'd0, oe1, oe0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oe_read: got %h want %h", got, exp); end
        cs = 1'b0; #1 got = {14'd0, oe1, oe0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL oe_idle: got %h want %h", got, exp); end
        @(negedge phi2);
        // With DDR=0 every port read returns the pad input.
        sb.push_back(16'h0033); sb.push_back(16'h0000); sb.push_back(16'h0096);
        sb.push_back(16'h0000);
        for (int a = 0; a < 4; a++) begin
            bus_read(5'(a), d);
            got = {8'h00, d}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL rst_read[%0d]: got %h want %h", a, got, exp);
            end
        end
    endtask

    task automatic test_ports;
        logic [7:0] d;
        bus_write(5'd1, 8'hF0);
        pin0[7:0] = 8'h3C;
        sb.push_back(16'h00AC); sb.push_back(16'h00A5); sb.push_back(16'h00F0);
        bus_write(5'd0, 8'hA5);
        bus_read(5'd0, d);
        got = {8'h00, d}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL port_mix: got %h want %h", got, exp); end
        got = {8'h00, port0[7:0]}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL port_o0: got %h want %h", got, exp); end
        got = {8'h00, ddr0[7:0]}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ddr_o0: got %h want %h", got, exp); end
    endtask

    task automatic test_timer_div8;
        logic [7:0] d;
        bus_write(5'd9, 8'h03);
        addr = 5'd16;
        for (int k = 0; k < 35; k++) begin
            sb.push_back(k < 32 ? 16'(3 - k / 8) : 16'(255 - (k - 32)));
            #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL tmr_count[%0d]: got %h want %h", k, got, exp);
            end
            @(negedge phi2);
        end
        sb.push_back(16'h0080); sb.push_back(16'h0000); sb.push_back(16'h0001);
        bus_read(5'd17, d);
        got = {8'h00, d}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tflag_set: got %h want %h", got, exp); end
        bus_read(5'd16, d);
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tflag_clr: got %h want %h", got, exp); end
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_masked: got %h want %h", got, exp); end
    endtask

    task automatic test_timer_irq;
        bus_write(5'd12, 8'h00);
        sb.push_back(16'h0001); sb.push_back(16'h0001); sb.push_back(16'h0080);
        sb.push_back(16'h0000); sb.push_back(16'h0000);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_t0: got %h want %h", got, exp); end
        idle(1);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_t1: got %h want %h", got, exp); end
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tflag_t1: got %h want %h", got, exp); end
        idle(1);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_t2: got %h want %h", got, exp); end
        idle(254);
        addr = 5'd16; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL count_zero: got %h want %h", got, exp); end
        // Reload in the very cycle the count-0 tick would time out.
        bus_write(5'd12, 8'h40);
        sb.push_back(16'h0000); sb.push_back(16'h0040); sb.push_back(16'h0000);
        sb.push_back(16'h0001);
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL load_wins: got %h want %h", got, exp); end
        addr = 5'd16; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reload_cnt: got %h want %h", got, exp); end
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_lag: got %h want %h", got, exp); end
        idle(1);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_release: got %h want %h", got, exp); end
        bus_write(5'd11, 8'hFF);
    endtask

    task automatic test_edge;
`ifdef RIOT_EDGE_IRQ_EN
        logic [7:0] d;
        bus_write(5'd17, 8'h11);
        pin0[7] = 1'b1;
        sb.push_back(16'h0001); sb.push_back(16'h0000); sb.push_back(16'h0001);
        sb.push_back(16'h0000); sb.push_back(16'h0001);
        idle(1);
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_rise: got %h want %h", got, exp); end
        idle(1);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_irq: got %h want %h", got, exp); end
        bus_read(5'd17, d);
        got = {8'h00, d}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_rd: got %h want %h", got, exp); end
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_clr: got %h want %h", got, exp); end
        idle(1);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_irq_clr: got %h want %h", got, exp); end
        pin0[7] = 1'b0;
        sb.push_back(16'h0000); sb.push_back(16'h0001);
        idle(2);
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_fall: got %h want %h", got, exp); end
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL edge_fall_irq: got %h want %h", got, exp); end
`else
        // Without edge logic a rising edge and a control write have no effect.
        bus_write(5'd17, 8'h11);
        pin0[7] = 1'b1;
        sb.push_back(16'h0000); sb.push_back(16'h0001);
        idle(2);
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL noedge_stat: got %h want %h", got, exp); end
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL noedge_irq: got %h want %h", got, exp); end
        pin0[7] = 1'b0;
        idle(1);
`endif
    endtask

    task automatic test_narrow;
        bus_write(5'd2, 8'h55);
        bus_write(5'd3, 8'h66);
        sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0005);
        sb.push_back(16'h0000);
        addr = 5'd2; #1 got = {8'h00, do1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_rd2: got %h want %h", got, exp); end
        addr = 5'd3; #1 got = {8'h00, do1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_rd3: got %h want %h", got, exp); end
        got = {12'd0, port1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_port: got %h want %h", got, exp); end
        got = {12'd0, ddr1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_ddr0: got %h want %h", got, exp); end
        bus_write(5'd1, 8'hFF);
        sb.push_back(16'h000F); sb.push_back(16'h000F); sb.push_back(16'h0005);
        got = {12'd0, ddr1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_ddr_o: got %h want %h", got, exp); end
        addr = 5'd1; #1 got = {8'h00, do1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_rd1: got %h want %h", got, exp); end
        addr = 5'd0; #1 got = {8'h00, do1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL n_rd0: got %h want %h", got, exp); end
    endtask

    task automatic test_mid_reset;
        bus_write(5'd12, 8'h00);
        idle(2);
        sb.push_back(16'h0000);
        got = {15'd0, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pre_rst_irq: got %h want %h", got, exp); end
        // Reset coincides with a DDR write that must be discarded.
        rst = 1'b1; cs = 1'b1; we_n = 1'b0; addr = 5'd1; di = 8'h77;
        sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0003);
        sb.push_back(16'h00FF); sb.push_back(16'h0000); sb.push_back(16'h0000);
        @(negedge phi2);
        cs = 1'b0; we_n = 1'b1; rst = 1'b0;
        got = port0; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mr_port_o: got %h want %h", got, exp); end
        got = ddr0; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mr_ddr_o: got %h want %h", got, exp); end
        got = {14'd0, irq1, irq0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mr_irq_n: got %h want %h", got, exp); end
        addr = 5'd16; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mr_count: got %h want %h", got, exp); end
        addr = 5'd17; #1 got = {8'h00, do0}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mr_status: got %h want %h", got, exp); end
        got = {8'h00, port1, ddr1}; exp = sb.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mr_narrow: got %h want %h", got, exp); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; cs = 1'b0; we_n = 1'b1; addr = 5'd0; di = 8'h00;
        pin0 = 16'h9633; pin1 = 4'h9;
        repeat (3) @(negedge phi2);
        rst = 1'b0;
        test_reset();
        test_ports();
        test_timer_div8();
        test_timer_irq();
        test_edge();
        test_narrow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
